// File: rtl/gray_code_counter_pkg.sv
// Shared definitions for the Gray code counter and its Gray-sample monitor.
//   - DEFAULT_WIDTH / DEFAULT_ERR_CNT_W : default parameter values for the top
//   - bin2gray / gray2bin               : conversions on a 32-bit container;
//     callers zero-extend narrower values and truncate the result. Leading
//     zeros do not change either conversion, so this holds for any width up to 32.
package gray_code_counter_pkg;

    localparam int DEFAULT_WIDTH     = 4;
    localparam int DEFAULT_ERR_CNT_W = 8;
    localparam int MAX_WIDTH         = 32;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_code_counter_gray2bin_dec.sv
// Purely combinational Gray-to-binary decoder.
//   gray : input  WIDTH  Gray-coded value
//   bin  : output WIDTH  binary decode (b[MSB] = g[MSB], b[i] = b[i+1] ^ g[i])
module gray2bin_dec
    import gray_code_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic [MAX_WIDTH-1:0] bin_full;

    assign bin_full = gray2bin(MAX_WIDTH'(gray));
    assign bin      = bin_full[WIDTH-1:0];

endmodule

// File: rtl/gray_code_counter.sv
// Up/down counter with registered binary and Gray outputs, plus an independent
// monitor that decodes an external Gray stream and flags illegal steps.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en, up_dn           : count enable, direction (1 = up)
//   load, load_val      : synchronous load (has priority over en)
//   gray_q, bin_q, wrap : registered count (Gray / binary), wrap-around pulse
//   g_in, g_vld         : external Gray sample and qualifier
//   bin_out, bin_vld    : registered decode of g_in and its qualifier
//   step_err, err_cnt   : illegal-step pulse, saturating error count
module gray_code_counter
    import gray_code_counter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ERR_CNT_W = DEFAULT_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    output logic [WIDTH-1:0]     gray_q,
    output logic [WIDTH-1:0]     bin_q,
    output logic                 wrap,
    input  logic [WIDTH-1:0]     g_in,
    input  logic                 g_vld,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_vld,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // ---------------- counter ----------------
    logic [WIDTH-1:0]     bin_nxt;
    logic                 wrap_nxt;
    logic [MAX_WIDTH-1:0] gray_nxt_full;

    always_comb begin
        bin_nxt  = bin_q;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_val;
        end else if (en) begin
            if (up_dn) begin
                bin_nxt  = bin_q + WIDTH'(1);
                wrap_nxt = (bin_q == '1);
            end else begin
                bin_nxt  = bin_q - WIDTH'(1);
                wrap_nxt = (bin_q == '0);
            end
        end
    end

    // Gray output is registered from the next binary value so both outputs
    // change on the same edge and gray_q never glitches.
    assign gray_nxt_full = bin2gray(MAX_WIDTH'(bin_nxt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap   <= 1'b0;
        end else begin
            bin_q  <= bin_nxt;
            gray_q <= gray_nxt_full[WIDTH-1:0];
            wrap   <= wrap_nxt;
        end
    end

    // ---------------- monitor ----------------
    logic [WIDTH-1:0] g_prev;
    logic             have_prev;
    logic [WIDTH-1:0] dec_bin;
    logic [WIDTH-1:0] g_diff;
    logic             multi_bit;

    gray2bin_dec #(
        .WIDTH (WIDTH)
    ) u_dec (
        .gray (g_in),
        .bin  (dec_bin)
    );

    // More than one bit differs iff clearing the lowest set bit leaves any set.
    assign g_diff    = g_in ^ g_prev;
    assign multi_bit = ((g_diff & (g_diff - WIDTH'(1))) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out   <= '0;
            bin_vld   <= 1'b0;
            step_err  <= 1'b0;
            err_cnt   <= '0;
            g_prev    <= '0;
            have_prev <= 1'b0;
        end else begin
            bin_vld  <= 1'b0;
            step_err <= 1'b0;
            if (g_vld) begin
                bin_out   <= dec_bin;
                bin_vld   <= 1'b1;
                g_prev    <= g_in;
                have_prev <= 1'b1;
                if (have_prev && multi_bit) begin
                    step_err <= 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + ERR_CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_code_counter.sv
module tb_gray_code_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up_dn, load, g_vld;
    logic [3:0] load_val, g_in;

    logic [3:0] gray_q, bin_q, bin_out;
    logic       wrap, bin_vld, step_err;
    logic [7:0] err_cnt;

    logic [3:0] s_gray_q, s_bin_q, s_bin_out;
    logic       s_wrap, s_bin_vld, s_step_err;
    logic [1:0] s_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gray_code_counter dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .gray_q(gray_q), .bin_q(bin_q), .wrap(wrap),
        .g_in(g_in), .g_vld(g_vld), .bin_out(bin_out), .bin_vld(bin_vld),
        .step_err(step_err), .err_cnt(err_cnt)
    );

    gray_code_counter #(.WIDTH(4), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .gray_q(s_gray_q), .bin_q(s_bin_q), .wrap(s_wrap),
        .g_in(g_in), .g_vld(g_vld), .bin_out(s_bin_out), .bin_vld(s_bin_vld),
        .step_err(s_step_err), .err_cnt(s_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".bin_q"},    32'(bin_q),    0);
        chk({tag, ".gray_q"},   32'(gray_q),   0);
        chk({tag, ".wrap"},     32'(wrap),     0);
        chk({tag, ".bin_out"},  32'(bin_out),  0);
        chk({tag, ".bin_vld"},  32'(bin_vld),  0);
        chk({tag, ".step_err"}, 32'(step_err), 0);
        chk({tag, ".err_cnt"},  32'(err_cnt),  0);
        chk({tag, ".s_err_cnt"}, 32'(s_err_cnt), 0);
    endtask

    // Hand-computed Gray codes for binary 1..15 then 0.
    logic [3:0] gray_up [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    // Legal monitor stream and its hand-decoded binaries.
    logic [3:0] mon_g [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
    logic [3:0] mon_b [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    // Illegal-step stream after a stored 1111, with expected saturated counts.
    logic [3:0] bad_g [5] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000};
    logic [1:0] sat_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst_n = 1'b0; en = 0; up_dn = 0; load = 0; g_vld = 0;
        load_val = '0; g_in = '0;
        #12;
        chk_all_zero("reset");
        tick();
        rst_n = 1'b1;

        // Count up through a full wrap.
        en = 1; up_dn = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("up%0d.bin_q", i),  32'(bin_q),  32'(i % 16));
            chk($sformatf("up%0d.gray_q", i), 32'(gray_q), 32'(gray_up[i-1]));
            chk($sformatf("up%0d.wrap", i),   32'(wrap),   (i == 16) ? 1 : 0);
        end

        // Load wins over en; then decrement wraps 0 -> 15.
        load = 1; load_val = 4'd0; en = 1; up_dn = 0;
        tick();
        chk("load0.bin_q", 32'(bin_q), 0);
        chk("load0.wrap",  32'(wrap),  0);
        load = 0;
        tick();
        chk("dn_wrap.bin_q",  32'(bin_q),  15);
        chk("dn_wrap.gray_q", 32'(gray_q), 32'b1000);
        chk("dn_wrap.wrap",   32'(wrap),   1);
        en = 0;
        tick();
        chk("hold.bin_q", 32'(bin_q), 15);
        chk("hold.wrap",  32'(wrap),  0);
        // Load from all-ones with up enabled must not report a wrap.
        load = 1; load_val = 4'd6; en = 1; up_dn = 1;
        tick();
        chk("load6.bin_q",  32'(bin_q),  6);
        chk("load6.gray_q", 32'(gray_q), 32'b0101);
        chk("load6.wrap",   32'(wrap),   0);
        load = 0; en = 0;

        // Legal monitor stream.
        g_vld = 1;
        for (int i = 0; i < 5; i++) begin
            g_in = mon_g[i];
            tick();
            chk($sformatf("mon%0d.bin_out", i),  32'(bin_out),  32'(mon_b[i]));
            chk($sformatf("mon%0d.bin_vld", i),  32'(bin_vld),  1);
            chk($sformatf("mon%0d.step_err", i), 32'(step_err), 0);
        end
        g_vld = 0; g_in = 4'b1111;
        tick();
        chk("idle.bin_vld", 32'(bin_vld), 0);
        chk("idle.bin_out", 32'(bin_out), 4);
        chk("idle.err_cnt", 32'(err_cnt), 0);

        // Fresh reset, then an illegal step and a repeat.
        rst_n = 0; #2; rst_n = 1;
        g_vld = 1; g_in = 4'b0000;
        tick();
        chk("e0.step_err", 32'(step_err), 0);
        g_in = 4'b0011;
        tick();
        chk("e1.step_err", 32'(step_err), 1);
        chk("e1.err_cnt",  32'(err_cnt),  1);
        chk("e1.bin_out",  32'(bin_out),  2);
        tick();
        chk("e2.step_err", 32'(step_err), 0);
        chk("e2.err_cnt",  32'(err_cnt),  1);
        g_in = 4'b0000;
        tick();
        chk("e3.err_cnt", 32'(err_cnt), 2);
        g_vld = 0;
        tick();
        chk("e4.step_err", 32'(step_err), 0);

        // Count to 9, then reset mid-count.
        load = 1; load_val = 4'd8;
        tick();
        load = 0; en = 1; up_dn = 1;
        tick();
        chk("pre_rst.bin_q",   32'(bin_q),   9);
        chk("pre_rst.err_cnt", 32'(err_cnt), 2);
        en = 0;
        rst_n = 0;
        #2;
        chk_all_zero("mid_rst");
        rst_n = 1;
        g_vld = 1; g_in = 4'b1111;
        tick();
        chk("post_rst.step_err", 32'(step_err), 0);
        chk("post_rst.bin_out",  32'(bin_out),  10);
        chk("post_rst.bin_q",    32'(bin_q),    0);

        // Five illegal steps while counting up concurrently.
        en = 1; up_dn = 1;
        for (int i = 0; i < 5; i++) begin
            g_in = bad_g[i];
            tick();
            chk($sformatf("sat%0d.step_err", i),  32'(step_err),  1);
            chk($sformatf("sat%0d.err_cnt", i),   32'(err_cnt),   32'(i + 1));
            chk($sformatf("sat%0d.s_err_cnt", i), 32'(s_err_cnt), 32'(sat_c[i]));
            chk($sformatf("sat%0d.bin_q", i),     32'(bin_q),     32'(i + 1));
        end
        g_vld = 0; en = 0;
        tick();
        chk("end.step_err", 32'(step_err), 0);
        chk("end.s_bin_q",  32'(s_bin_q),  5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
